des_cbc_ctrl: RTL and testbench
===============================

Name: des_cbc_ctrl

Overview:
Sequential mode controller that sits directly upstream and downstream of the combinational DES core. It feeds the core's key, block and encrypt inputs, then consumes its ciphertext and OddParity outputs. It adds CBC chaining, a key/IV register file, valid/ready streaming handshakes and key-parity error flagging, which turns the single-shot core into a streaming block cipher.

Parameters:
SETTLE_CYCLES, 1, cycles the core inputs are held stable before des_dout is sampled (range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
key_load  input  1  pulse: capture key_in (accepted only in IDLE)
key_in  input  64  DES key including parity bits
iv_load  input  1  pulse: capture iv_in as chain value (accepted only in IDLE)
iv_in  input  64  initialisation vector
mode_encrypt  input  1  1 = CBC encrypt, 0 = CBC decrypt; sampled with each accepted block
in_valid  input  1  input block valid
in_ready  output  1  block accepted when in_valid & in_ready
in_data  input  64  plaintext (encrypt) or ciphertext (decrypt)
out_valid  output  1  result valid
out_ready  input  1  downstream ready
out_data  output  64  result block
key_err  output  1  sticky: a block was processed with a key failing odd parity
des_key  output  64  to core key
des_encrypt  output  1  to core encrypt
des_din  output  64  to core plaintext input
des_dout  input  64  from core ciphertext output
des_parity  input  8  from core OddParity

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, key_err=0, des_key=0, des_din=0, des_encrypt=0, key/chain/blk registers=0, state=IDLE, counter=0.
- FSM states: IDLE, CORE, OUT.
- IDLE: in_ready=1 unless key_load or iv_load is asserted in the same cycle.
  - key_load has priority: key register<=key_in and key_err<=0.
  - iv_load in the same cycle is also captured: chain<=iv_in.
  - A block cannot be accepted in a cycle with a load.
- Acceptance (in_valid & in_ready): register the block and mode, drive the core inputs, counter<=SETTLE_CYCLES-1, go to CORE.
  - Encrypt: des_din <= in_data ^ chain.
  - Decrypt: des_din <= in_data, with in_data saved as blk.
- CORE: counter decrements each cycle. When counter==0:
  - Sample des_dout into out_data:
    - encrypt: out_data <= des_dout; chain <= des_dout.
    - decrypt: out_data <= des_dout ^ chain; chain <= blk.
  - If des_parity != 8'hFF, key_err<=1.
  - Set out_valid<=1 and go to OUT.
- OUT: out_valid held with out_data stable until out_ready. On out_valid & out_ready: out_valid<=0, go to IDLE.
- Latency: out_valid rises SETTLE_CYCLES+1 cycles after the accepting edge. Maximum throughput is one block per SETTLE_CYCLES+2 cycles.
- key_load and iv_load outside IDLE are ignored (no effect, no error).
- in_valid deasserted while in_ready is high: nothing happens.
- The chain value persists across blocks until iv_load or reset. Alternating mode_encrypt between blocks uses the current chain as-is.
- reset mid-operation: the in-flight block is discarded, chain/key are cleared, no out_valid is produced.
- key_err is cleared only by reset or an accepted key_load.

Optional Feature:
DES_CBC_ECB_EN:
- Defined: adds input port ecb (1 bit), sampled with the accepted block. When ecb=1, the chain is neither XORed into the block nor updated: des_din=in_data and out_data=des_dout in both modes.
- Undefined: no ecb port; every block is CBC.

Decomposition:
- Shared package des_pkg: typedef des_block_t (logic [63:0]); typedef enum des_cbc_state_t {IDLE, CORE, OUT}; constant DES_PARITY_OK = 8'hFF.
- No sub-module. The DES core is instantiated beside this block at the next level up and connected via the des_* ports.
- The bench instantiates both together.

Test Plan:
- Reset, then key_load 133457799BBCDFF1, iv_load 0, encrypt block 0123456789ABCDEF -> out_data 85E813540F0AB405, key_err 0, out_valid at SETTLE_CYCLES+1 cycles after accept.
- Continue the chain: encrypt 84CB563386A179EA -> out_data 85E813540F0AB405 (the chain XOR restores the first plaintext).
- iv_load 0, decrypt 85E813540F0AB405 then 85E813540F0AB405 -> 0123456789ABCDEF then 84CB563386A179EA.
- key_load 133457799BBCDFF0 (bad parity in the last byte), encrypt any block -> key_err 1 and stays 1. Next key_load of a good key clears it.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready 0. key_load during OUT is ignored (next result still uses the old key).
- Assert reset while in CORE -> out_valid never rises, all outputs return to 0. With DES_CBC_ECB_EN and ecb=1, two identical plaintexts give identical ciphertexts 85E813540F0AB405.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and constants for the DES CBC mode controller
package des_pkg;

    typedef logic [63:0] des_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        OUT  = 2'd2
    } des_cbc_state_t;

    localparam logic [7:0] DES_PARITY_OK = 8'hFF;

    // Core reports one OddParity bit per key byte; all must be set
    function automatic logic parity_ok(input logic [7:0] p);
        return p == DES_PARITY_OK;
    endfunction

endpackage

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - CBC streaming controller wrapped around a combinational DES core
// Optional ECB bypass port (ecb) is built when DES_CBC_ECB_EN is defined.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        iv_load,
    input  logic [63:0] iv_in,
    input  logic        mode_encrypt,
`ifdef DES_CBC_ECB_EN
    input  logic        ecb,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        key_err,
    output logic [63:0] des_key,
    output logic        des_encrypt,
    output logic [63:0] des_din,
    input  logic [63:0] des_dout,
    input  logic [7:0]  des_parity
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    des_cbc_state_t state;
    logic [3:0]     cnt;
    logic           ready_q;
    logic           ecb_sel;
    logic           ecb_q;
    des_block_t     chain;
    des_block_t     blk;

`ifdef DES_CBC_ECB_EN
    assign ecb_sel = ecb;
`else
    assign ecb_sel = 1'b0;
`endif

    // A load cycle always blocks acceptance so key/IV updates never race a block
    assign in_ready = ready_q & ~key_load & ~iv_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b0;
            ecb_q       <= 1'b0;
            chain       <= '0;
            blk         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            key_err     <= 1'b0;
            des_key     <= '0;
            des_din     <= '0;
            des_encrypt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (key_load) begin
                        des_key <= key_in;
                        key_err <= 1'b0;
                    end
                    if (iv_load) begin
                        chain <= iv_in;
                    end
                    if (in_valid && in_ready) begin
                        des_encrypt <= mode_encrypt;
                        ecb_q       <= ecb_sel;
                        blk         <= in_data;
                        des_din     <= (mode_encrypt && !ecb_sel) ? (in_data ^ chain) : in_data;
                        cnt         <= CNT_INIT;
                        ready_q     <= 1'b0;
                        state       <= CORE;
                    end
                end
                CORE: begin
                    if (cnt == 4'd0) begin
                        if (ecb_q || des_encrypt) begin
                            out_data <= des_dout;
                        end else begin
                            out_data <= des_dout ^ chain;
                        end
                        // Next chain value: ciphertext of this block in either direction
                        if (!ecb_q) begin
                            chain <= des_encrypt ? des_dout : blk;
                        end
                        if (!parity_ok(des_parity)) begin
                            key_err <= 1'b1;
                        end
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb/tb_des_cbc_ctrl.sv - scoreboard bench for des_cbc_ctrl with a behavioural DES core beside it
module tb_des_cbc_ctrl;

    localparam int S = 3;

    localparam logic [63:0] K_GOOD  = 64'h133457799BBCDFF1;
    localparam logic [63:0] K_BAD   = 64'h133457799BBCDFF0;
    localparam logic [63:0] K_OTHER = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P1      = 64'h0123456789ABCDEF;
    localparam logic [63:0] P2      = 64'h84CB563386A179EA;
    localparam logic [63:0] C1      = 64'h85E813540F0AB405;

    localparam int IP_T [0:63] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                   62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                   57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                   61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T [0:63] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                   38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                   36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                   34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T [0:47] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                  16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T [0:31] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T [0:55] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                                    10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                                    14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T [0:47] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                                    26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                                    51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFT_T [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SBOX [0:7][0:63] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_load = 1'b0;
    logic        iv_load = 1'b0;
    logic        mode_encrypt = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ecb_s = 1'b0;
    logic [63:0] key_in = '0;
    logic [63:0] iv_in = '0;
    logic [63:0] in_data = '0;
    logic        in_ready, out_valid, key_err, des_encrypt;
    logic [63:0] out_data, des_key, des_din, des_dout;
    logic [7:0]  des_parity;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] data;
        logic        kerr;
    } exp_t;
    exp_t sb[$];

    logic [63:0] m_key = '0;
    logic [63:0] m_chain = '0;
    logic        m_kerr = 1'b0;
    bit          bp_hold = 1'b0;

    des_cbc_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .key_load(key_load), .key_in(key_in),
        .iv_load(iv_load), .iv_in(iv_in),
        .mode_encrypt(mode_encrypt),
`ifdef DES_CBC_ECB_EN
        .ecb(ecb_s),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_err(key_err),
        .des_key(des_key), .des_encrypt(des_encrypt), .des_din(des_din),
        .des_dout(des_dout), .des_parity(des_parity)
    );

    function automatic logic [63:0] des_fn(input logic [63:0] key, input logic [63:0] din, input logic enc);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [63:0] b, pre, res;
        logic [31:0] l, r, f, pf, t;
        logic [47:0] e;
        logic [5:0]  six;
        int          v, row, col;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFT_T[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) b[63-i] = din[64-IP_T[i]];
        l = b[63:32];
        r = b[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ (enc ? ks[n] : ks[15-n]);
            for (int s = 0; s < 8; s++) begin
                six = e[47-6*s -: 6];
                row = {30'd0, six[5], six[0]};
                col = {28'd0, six[4:1]};
                v = SBOX[s][row*16+col];
                f[31-4*s -: 4] = v[3:0];
            end
            for (int i = 0; i < 32; i++) pf[31-i] = f[32-P_T[i]];
            t = l ^ pf;
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    function automatic logic key_parity_good(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Environment: combinational DES core beside the controller
    always_comb begin
        des_dout = des_fn(des_key, des_din, des_encrypt);
        for (int b = 0; b < 8; b++) des_parity[b] = ^des_key[8*b +: 8];
    end

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [63:0] d, input logic enc, input logic e);
        exp_t        x;
        logic [63:0] r;
        if (e) begin
            r = des_fn(m_key, d, enc);
        end else if (enc) begin
            r = des_fn(m_key, d ^ m_chain, 1'b1);
            m_chain = r;
        end else begin
            r = des_fn(m_key, d, 1'b0) ^ m_chain;
            m_chain = d;
        end
        if (!key_parity_good(m_key)) m_kerr = 1'b1;
        x.data = r;
        x.kerr = m_kerr;
        sb.push_back(x);
    endtask

    // Monitor: every completed output handshake is checked against the scoreboard
    initial forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                check("out_data", out_data, x.data);
                check("out_key_err", 64'(key_err), 64'(x.kerr));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_hold ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic load(input bit do_key, input logic [63:0] k, input bit do_iv,
                        input logic [63:0] iv, input bit taken);
        @(posedge clk);
        #1;
        key_load = do_key;
        key_in   = k;
        iv_load  = do_iv;
        iv_in    = iv;
        @(negedge clk);
        check("in_ready_in_load", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        key_load = 1'b0;
        iv_load  = 1'b0;
        if (taken) begin
            if (do_key) begin
                m_key  = k;
                m_kerr = 1'b0;
            end
            if (do_iv) m_chain = iv;
        end
    endtask

    task automatic issue(input logic [63:0] d, input logic enc, input logic e,
                         input bit has_kat, input logic [63:0] kat);
        int g = 0;
        int n = 0;
        @(posedge clk);
        #1;
        in_data      = d;
        mode_encrypt = enc;
        ecb_s        = e;
        in_valid     = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("accept", 64'(in_ready), 64'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        model_push(d, enc, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        check("latency", 64'(n), 64'(S + 1));
        if (has_kat) check("kat", out_data, kat);
    endtask

    task automatic drain();
        int g = 0;
        while (out_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain", 64'(out_valid), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_key_err"}, 64'(key_err), 64'd0);
        check({tag, "_des_key"}, des_key, 64'd0);
        check({tag, "_des_din"}, des_din, 64'd0);
        check({tag, "_des_encrypt"}, 64'(des_encrypt), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int          seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        load(1'b1, K_GOOD, 1'b1, 64'd0, 1'b1);
        issue(P1, 1'b1, 1'b0, 1'b1, C1);
        drain();
        issue(P2, 1'b1, 1'b0, 1'b1, C1);
        drain();
        load(1'b0, 64'd0, 1'b1, 64'd0, 1'b1);
        issue(C1, 1'b0, 1'b0, 1'b1, P1);
        drain();
        issue(C1, 1'b0, 1'b0, 1'b1, P2);
        drain();

        for (int i = 0; i < 8; i++) begin
            issue({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 64'd0);
            drain();
        end

        load(1'b1, K_BAD, 1'b0, 64'd0, 1'b1);
        issue({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'd0);
        drain();
        check("key_err_set", 64'(key_err), 64'd1);
        issue({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 64'd0);
        drain();
        check("key_err_sticky", 64'(key_err), 64'd1);
        load(1'b1, K_GOOD, 1'b0, 64'd0, 1'b1);
        @(negedge clk);
        check("key_err_cleared", 64'(key_err), 64'd0);

        // Backpressure with an ignored key_load during OUT
        bp_hold = 1'b1;
        issue({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'd0);
        held = out_data;
        load(1'b1, K_OTHER, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        check("bp_des_key_kept", des_key, m_key);
        bp_hold = 1'b0;
        drain();
        issue({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'd0);
        drain();

        // Reset while a block is in CORE
        load(1'b1, K_BAD, 1'b0, 64'd0, 1'b1);
        issue({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 64'd0);
        drain();
        @(posedge clk);
        #1;
        in_data      = {$urandom, $urandom};
        mode_encrypt = 1'b1;
        in_valid     = 1'b1;
        @(negedge clk);
        check("accept_pre_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_key   = '0;
        m_chain = '0;
        m_kerr  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_out_after_reset", 64'(seen), 64'd0);

        load(1'b1, K_GOOD, 1'b0, 64'd0, 1'b1);
        issue(P1, 1'b1, 1'b0, 1'b1, C1);
        drain();

`ifdef DES_CBC_ECB_EN
        issue(P1, 1'b1, 1'b1, 1'b1, C1);
        drain();
        issue(P1, 1'b1, 1'b1, 1'b1, C1);
        drain();
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
